// File: rtl/mcu_scheduler.sv
// MCU sequencing controller for the entropy-decoding datapath: block/channel
// position, downstream credit gating, restart-marker handling and frame end.
module mcu_scheduler #(
  parameter int unsigned CH       = 3,
  parameter int unsigned Y_BLOCKS = 4,
  parameter int unsigned CREDITS  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [15:0]               mcus_total,
  input  logic [15:0]               restart_interval,
  input  logic                      blk_done,
  input  logic                      ds_ack,
  input  logic                      marker_ack,
  input  logic [2:0]                marker_num,
  output logic [$clog2(CH+1)-1:0]   ch,
  output logic                      decode_en,
  output logic                      dc_reset,
  output logic                      marker_req,
  output logic [15:0]               mcu_cnt,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      marker_err
);

  localparam int unsigned NBLK = Y_BLOCKS + CH - 1;
  localparam int unsigned BW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int unsigned CRW  = $clog2(CREDITS + 1);
  localparam int unsigned CHW  = $clog2(CH + 1);

  localparam logic [BW-1:0]  LAST_BLK  = BW'(NBLK - 1);
  localparam logic [BW-1:0]  FIRST_C   = BW'(Y_BLOCKS);
  localparam logic [BW-1:0]  C_OFFSET  = BW'(Y_BLOCKS - 1);
  localparam logic [CRW-1:0] CRED_MAX  = CRW'(CREDITS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DECODE  = 2'd1;
  localparam logic [1:0] S_RESTART = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]     state_q,      state_d;
  logic [BW-1:0]  blk_idx_q,    blk_idx_d;
  logic [15:0]    mcu_cnt_q,    mcu_cnt_d;
  logic [15:0]    rst_cnt_q,    rst_cnt_d;
  logic [2:0]     exp_marker_q, exp_marker_d;
  logic [CRW-1:0] credits_q,    credits_d;
  logic           dc_reset_q,   dc_reset_d;
  logic           marker_err_q, marker_err_d;
  logic [15:0]    total_q,      total_d;
  logic [15:0]    interval_q,   interval_d;

  logic        blk_ev;
  logic [15:0] mcu_inc;
  logic [15:0] rst_inc;

  always_comb begin
    state_d      = state_q;
    blk_idx_d    = blk_idx_q;
    mcu_cnt_d    = mcu_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    exp_marker_d = exp_marker_q;
    credits_d    = credits_q;
    dc_reset_d   = 1'b0;
    marker_err_d = marker_err_q;
    total_d      = total_q;
    interval_d   = interval_q;

    blk_ev  = blk_done && (state_q == S_DECODE);
    mcu_inc = mcu_cnt_q + 16'd1;
    rst_inc = rst_cnt_q + 16'd1;

    // Credit return is honoured in every state; only DECODE consumes.
    unique case ({ds_ack, blk_ev})
      2'b10: if (credits_q != CRED_MAX) credits_d = credits_q + CRW'(1);
      2'b01: if (credits_q != '0)       credits_d = credits_q - CRW'(1);
      default: ;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          total_d      = mcus_total;
          interval_d   = restart_interval;
          blk_idx_d    = '0;
          mcu_cnt_d    = '0;
          rst_cnt_d    = '0;
          exp_marker_d = '0;
          credits_d    = CRED_MAX;
          marker_err_d = 1'b0;
          if (mcus_total == '0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_DECODE;
            dc_reset_d = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (blk_ev) begin
          if (blk_idx_q == LAST_BLK) begin
            blk_idx_d = '0;
            mcu_cnt_d = mcu_inc;
            rst_cnt_d = rst_inc;
            // Frame end wins over a coincident restart boundary.
            if (mcu_inc == total_q) begin
              state_d = S_DONE;
            end else if ((interval_q != '0) && (rst_inc == interval_q)) begin
              state_d = S_RESTART;
            end
          end else begin
            blk_idx_d = blk_idx_q + BW'(1);
          end
        end
      end
      S_RESTART: begin
        if (marker_ack) begin
          dc_reset_d   = 1'b1;
          rst_cnt_d    = '0;
          state_d      = S_DECODE;
          exp_marker_d = exp_marker_q + 3'd1;
          if (marker_num != exp_marker_q) marker_err_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      blk_idx_q    <= '0;
      mcu_cnt_q    <= '0;
      rst_cnt_q    <= '0;
      exp_marker_q <= '0;
      credits_q    <= CRED_MAX;
      dc_reset_q   <= 1'b0;
      marker_err_q <= 1'b0;
      total_q      <= '0;
      interval_q   <= '0;
    end else begin
      state_q      <= state_d;
      blk_idx_q    <= blk_idx_d;
      mcu_cnt_q    <= mcu_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      exp_marker_q <= exp_marker_d;
      credits_q    <= credits_d;
      dc_reset_q   <= dc_reset_d;
      marker_err_q <= marker_err_d;
      total_q      <= total_d;
      interval_q   <= interval_d;
    end
  end

  always_comb begin
    if (blk_idx_q < FIRST_C) ch = '0;
    else                     ch = CHW'(blk_idx_q - C_OFFSET);
  end

  assign decode_en  = (state_q == S_DECODE) && (credits_q != '0);
  assign dc_reset   = dc_reset_q;
  assign marker_req = (state_q == S_RESTART);
  assign mcu_cnt    = mcu_cnt_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);
  assign marker_err = marker_err_q;

endmodule

// File: tb/tb_mcu_scheduler.sv
// Scoreboard bench for mcu_scheduler: stimulus queues expected channel and
// frame-end results; a negedge monitor pops and compares them.
module tb_mcu_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic [15:0] mcus_total = '0;
  logic [15:0] restart_interval = '0;
  logic        blk_done = 1'b0;
  logic        ds_ack = 1'b0;
  logic        marker_ack = 1'b0;
  logic [2:0]  marker_num = '0;
  logic [1:0]  ch;
  logic        decode_en, dc_reset, marker_req, busy, frame_done, marker_err;
  logic [15:0] mcu_cnt;

  mcu_scheduler #(.CH(3), .Y_BLOCKS(4), .CREDITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcus_total(mcus_total),
    .restart_interval(restart_interval), .blk_done(blk_done), .ds_ack(ds_ack),
    .marker_ack(marker_ack), .marker_num(marker_num), .ch(ch),
    .decode_en(decode_en), .dc_reset(dc_reset), .marker_req(marker_req),
    .mcu_cnt(mcu_cnt), .busy(busy), .frame_done(frame_done),
    .marker_err(marker_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mcu;
    int err;
  } frame_t;

  int     exp_ch_q[$];
  frame_t exp_frame_q[$];
  int     n_pass = 0;
  int     n_total = 0;
  int     dc_cnt = 0;
  int     mreq_rises = 0;
  logic   mreq_prev = 1'b0;

  // Expected channel for block position 0..5 of an MCU (Y Y Y Y Cb Cr).
  int ch_seq[6] = '{0, 0, 0, 0, 1, 2};

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic unexpected(input string nm);
    n_total++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int total, input int ri);
    mcus_total = 16'(total);
    restart_interval = 16'(ri);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic blocks(input int first, input int n, input bit ack);
    for (int i = 0; i < n; i++) begin
      exp_ch_q.push_back(ch_seq[(first + i) % 6]);
      blk_done = 1'b1;
      ds_ack = ack;
      tick();
      blk_done = 1'b0;
      ds_ack = 1'b0;
    end
  endtask

  task automatic ack_marker(input int num);
    marker_ack = 1'b1;
    marker_num = 3'(num);
    tick();
    marker_ack = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 50) begin
      tick();
      k++;
    end
    chk(nm, int'(busy), 0);
  endtask

  // Monitor: compares DUT outputs against queued expectations.
  initial begin
    frame_t f;
    int e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (blk_done) begin
          if (exp_ch_q.size() == 0) unexpected("ch_extra_block");
          else begin
            e = exp_ch_q.pop_front();
            chk("ch", int'(ch), e);
          end
        end
        if (frame_done) begin
          if (exp_frame_q.size() == 0) unexpected("frame_done_extra");
          else begin
            f = exp_frame_q.pop_front();
            chk("frame_mcu_cnt", int'(mcu_cnt), f.mcu);
            chk("frame_marker_err", int'(marker_err), f.err);
          end
        end
        if (dc_reset) dc_cnt++;
        if (marker_req && !mreq_prev) mreq_rises++;
      end
      mreq_prev = marker_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc0, mr0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ch", int'(ch), 0);
    chk("rst_decode_en", int'(decode_en), 0);
    chk("rst_dc_reset", int'(dc_reset), 0);
    chk("rst_marker_req", int'(marker_req), 0);
    chk("rst_mcu_cnt", int'(mcu_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_marker_err", int'(marker_err), 0);
    rst_n = 1'b1;
    tick();

    // Two MCUs, no restarts, credit returned with every block.
    dc0 = dc_cnt;
    exp_frame_q.push_back('{2, 0});
    do_start(2, 0);
    chk("t1_decode_en", int'(decode_en), 1);
    blocks(0, 6, 1'b1);
    chk("t1_mid_mcu_cnt", int'(mcu_cnt), 1);
    blocks(0, 6, 1'b1);
    wait_idle("t1_end");
    chk("t1_dc_resets", dc_cnt - dc0, 1);
    chk("t1_final_mcu_cnt", int'(mcu_cnt), 2);

    // Restart every MCU, correct markers; a stray ack in DECODE is ignored.
    dc0 = dc_cnt; mr0 = mreq_rises;
    exp_frame_q.push_back('{3, 0});
    do_start(3, 1);
    ack_marker(5);
    blocks(0, 6, 1'b1);
    chk("t2_marker_req", int'(marker_req), 1);
    chk("t2_decode_en_off", int'(decode_en), 0);
    ack_marker(0);
    chk("t2_dc_reset_after_ack", int'(dc_reset), 1);
    chk("t2_decode_en_on", int'(decode_en), 1);
    blocks(0, 6, 1'b1);
    ack_marker(1);
    blocks(0, 6, 1'b1);
    wait_idle("t2_end");
    chk("t2_dc_resets", dc_cnt - dc0, 3);
    chk("t2_restarts", mreq_rises - mr0, 2);

    // Same, but second marker out of sequence.
    exp_frame_q.push_back('{3, 1});
    do_start(3, 1);
    blocks(0, 6, 1'b1);
    ack_marker(0);
    blocks(0, 6, 1'b1);
    ack_marker(3);
    chk("t2b_marker_err", int'(marker_err), 1);
    blocks(0, 6, 1'b1);
    wait_idle("t2b_end");

    // Frame end outranks restart on the same MCU.
    dc0 = dc_cnt; mr0 = mreq_rises;
    exp_frame_q.push_back('{1, 0});
    do_start(1, 1);
    blocks(0, 6, 1'b1);
    wait_idle("t3_end");
    chk("t3_no_marker_req", mreq_rises - mr0, 0);
    chk("t3_dc_resets", dc_cnt - dc0, 1);

    // Credit flow: saturation at 2, drop to 0, restore, simultaneous events.
    exp_frame_q.push_back('{1, 0});
    do_start(1, 0);
    ds_ack = 1'b1; tick(); tick(); ds_ack = 1'b0;
    blocks(0, 1, 1'b0);
    chk("t4_en_after_1", int'(decode_en), 1);
    blocks(1, 1, 1'b0);
    chk("t4_en_after_2", int'(decode_en), 0);
    ds_ack = 1'b1; tick(); ds_ack = 1'b0;
    chk("t4_en_restored", int'(decode_en), 1);
    blocks(2, 1, 1'b1);
    chk("t4_en_simul", int'(decode_en), 1);
    blocks(3, 1, 1'b0);
    chk("t4_en_drop_again", int'(decode_en), 0);
    ds_ack = 1'b1; tick(); tick(); ds_ack = 1'b0;
    blocks(4, 2, 1'b1);
    wait_idle("t4_end");

    // Empty frame: one-cycle busy, frame_done, no dc_reset.
    dc0 = dc_cnt;
    exp_frame_q.push_back('{0, 0});
    do_start(0, 0);
    chk("t5_busy_cycle", int'(busy), 1);
    chk("t5_frame_done", int'(frame_done), 1);
    tick();
    chk("t5_busy_fall", int'(busy), 0);
    chk("t5_no_dc_reset", dc_cnt - dc0, 0);

    // Start while busy is ignored.
    dc0 = dc_cnt;
    exp_frame_q.push_back('{1, 0});
    do_start(1, 0);
    blocks(0, 3, 1'b1);
    do_start(5, 0);
    chk("t5_busy_start_mcu", int'(mcu_cnt), 0);
    chk("t5_busy_start_busy", int'(busy), 1);
    blocks(3, 3, 1'b1);
    wait_idle("t5_busy_start_end");
    chk("t5_busy_start_dc", dc_cnt - dc0, 1);

    // Asynchronous reset while waiting for a marker abandons the frame.
    do_start(2, 1);
    blocks(0, 6, 1'b1);
    chk("t6_in_restart", int'(marker_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_marker_req", int'(marker_req), 0);
    chk("t6_rst_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_frame_q.push_back('{1, 0});
    do_start(1, 0);
    chk("t6_ch_restart", int'(ch), 0);
    blocks(0, 6, 1'b1);
    wait_idle("t6_end");

    tick();
    chk("ch_queue_drained", exp_ch_q.size(), 0);
    chk("frame_queue_drained", exp_frame_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
